// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the debounce block.
package debounce_pkg;

    // 10 ms at 50 MHz
    localparam int unsigned DEFAULT_STABLE_CYCLES = 500000;
    localparam int unsigned DEFAULT_SYNC_STAGES   = 2;

    // Number of stable cycles needed for a debounce window of `ms` milliseconds.
    function automatic int unsigned debounce_cycles(input int unsigned clk_hz,
                                                    input int unsigned ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/debounce_if.sv
// Signal bundle between a raw pin source and the debounced-level consumer.
interface debounce_if;

    logic noisy;
    logic clean;
    logic rise;
    logic fall;

    // Source side: drives the raw pin, observes the filtered level and strobes.
    modport master (
        output noisy,
        input  clean,
        input  rise,
        input  fall
    );

    // Debouncer side.
    modport slave (
        input  noisy,
        output clean,
        output rise,
        output fall
    );

endinterface

// File: rtl/sync_ff.sv
// N-stage flop chain bringing an asynchronous input into the clock domain.
module sync_ff #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // Shift the raw input through the chain; stage 0 is the only one seeing `d`.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/debounce.sv
// Debouncer: synchronises a noisy input, requires it to stay different from the
// current clean level for STABLE_CYCLES cycles before following it, and emits
// registered one-cycle rise/fall strobes alongside the new level.
module debounce
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int unsigned SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter logic        RESET_LEVEL   = 1'b0
) (
    input  logic       clock,
    input  logic       reset_n,
    debounce_if.slave  bus
);

    localparam int unsigned     CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic             s;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clean_q, clean_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (RESET_LEVEL)
    ) u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (bus.noisy),
        .q       (s)
    );

    // Count consecutive disagreeing cycles; any agreement restarts the window,
    // so the counter never passes CNT_MAX and never wraps.
    always_comb begin
        cnt_d   = '0;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (s != clean_q) begin
            if (cnt_q == CNT_MAX) begin
                clean_d = s;
                rise_d  = s;
                fall_d  = ~s;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State register; strobes land in the same cycle as the new clean level.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            clean_q <= RESET_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign bus.clean = clean_q;
    assign bus.rise  = rise_q;
    assign bus.fall  = fall_q;

endmodule

// File: tb/tb_debounce.sv
// Directed bench for debounce with STABLE_CYCLES=4, SYNC_STAGES=2, RESET_LEVEL=0.
module tb_debounce;

    logic clock;
    logic reset_n;
    int   tests;
    int   failed;

    debounce_if bus ();

    debounce #(
        .STABLE_CYCLES (4),
        .SYNC_STAGES   (2),
        .RESET_LEVEL   (1'b0)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs set afterwards are sampled at the following one.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    logic       v4  [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       v3  [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [5:0] hist;
    logic       exp_clean;
    logic       prev_clean;
    int         n_rise;
    int         n_fall;
    int         hold;

    initial begin
        tests   = 0;
        failed  = 0;
        reset_n = 1'b0;
        bus.noisy = 1'b0;

        // 1: held in reset while the pin toggles
        for (int i = 0; i < 14; i++) begin
            #7 bus.noisy = ~bus.noisy;
            check("rst_clean", {31'd0, bus.clean}, 32'd0);
            check("rst_strobe", {30'd0, bus.rise, bus.fall}, 32'd0);
        end
        step();
        bus.noisy = 1'b0;
        reset_n   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("post_rst_clean", {31'd0, bus.clean}, 32'd0);
        end

        // 2: clean rise, first sampled at edge k -> clean=1 after edge k+5
        bus.noisy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("rise_clean", {31'd0, bus.clean}, {31'd0, i >= 5});
            check("rise_strobe", {31'd0, bus.rise}, {31'd0, i == 5});
            check("rise_nofall", {31'd0, bus.fall}, 32'd0);
        end

        // 4: bounce 1,0,1,0 then zeros from cycle 3 -> fall after edge e+8
        for (int i = 0; i < 10; i++) begin
            bus.noisy = v4[i];
            step();
            check("bounce_clean", {31'd0, bus.clean}, {31'd0, i < 8});
            check("bounce_fall", {31'd0, bus.fall}, {31'd0, i == 8});
            check("bounce_norise", {31'd0, bus.rise}, 32'd0);
        end

        // 3: three-cycle glitch never reaches clean
        for (int i = 0; i < 10; i++) begin
            bus.noisy = v3[i];
            step();
            check("glitch_clean", {31'd0, bus.clean}, 32'd0);
            check("glitch_rise", {31'd0, bus.rise}, 32'd0);
        end

        // 5: reset mid-count discards the partial count
        bus.noisy = 1'b1;
        repeat (4) step();
        check("pre_rst_cnt", 32'(dut.cnt_q), 32'd2);
        reset_n = 1'b0;
        #1;
        check("midrst_clean", {31'd0, bus.clean}, 32'd0);
        check("midrst_cnt", 32'(dut.cnt_q), 32'd0);
        step();
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            check("rel_clean", {31'd0, bus.clean}, {31'd0, i >= 5});
            check("rel_rise", {31'd0, bus.rise}, {31'd0, i == 5});
        end

        // 6: 20 transitions, each held >= 10 cycles; clean lags the pin by 5 edges
        hist       = 6'b111111;
        prev_clean = 1'b1;
        n_rise     = 0;
        n_fall     = 0;
        for (int t = 0; t < 20; t++) begin
            bus.noisy = ~bus.noisy;
            hold = $urandom_range(15, 10);
            for (int c = 0; c < hold; c++) begin
                step();
                hist      = {hist[4:0], bus.noisy};
                exp_clean = hist[5];
                check("rnd_clean", {31'd0, bus.clean}, {31'd0, exp_clean});
                check("rnd_rise", {31'd0, bus.rise}, {31'd0, exp_clean & ~prev_clean});
                check("rnd_fall", {31'd0, bus.fall}, {31'd0, ~exp_clean & prev_clean});
                if (bus.rise === 1'b1) n_rise++;
                if (bus.fall === 1'b1) n_fall++;
                prev_clean = exp_clean;
            end
        end
        check("rnd_n_rise", 32'(n_rise), 32'd10);
        check("rnd_n_fall", 32'(n_fall), 32'd10);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
